// File: rtl/aes_mask_keygen.sv
// Mask-key source for the AES masking stage: xorshift128 generator with
// per-request multi-round stepping and a hard reseed budget.
module aes_mask_keygen #(
  parameter int unsigned ROUNDS       = 4,
  parameter int unsigned RESEED_LIMIT = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         seed_we,
  input  logic [127:0] seed,
  input  logic         next,
  output logic         ready,
  output logic [127:0] mask,
  output logic         mask_valid,
  output logic         reseed_req
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned RND_W   = 5;
  localparam int unsigned CNT_W   = 16;

  localparam logic [STATE_W-1:0] DEFAULT_SEED =
    128'h6a09e667_bb67ae85_3c6ef372_a54ff53a;
  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] GEN_LIMIT = CNT_W'(RESEED_LIMIT);

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] st_q, st_d;
  logic [STATE_W-1:0] st_step;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic [CNT_W-1:0]   gen_q, gen_d;
  logic [CNT_W-1:0]   gen_inc;
  logic [STATE_W-1:0] mask_d;
  logic               ready_d;
  logic               mask_valid_d;
  logic               reseed_req_d;

  // One xorshift128 step on {x, y, z, w}.
  function automatic logic [STATE_W-1:0] xs_step(input logic [STATE_W-1:0] s);
    logic [31:0] x, y, z, w, t, w_n;
    x   = s[127:96];
    y   = s[95:64];
    z   = s[63:32];
    w   = s[31:0];
    t   = x ^ (x << 11);
    w_n = w ^ (w >> 19) ^ t ^ (t >> 8);
    return {y, z, w, w_n};
  endfunction

  assign st_step = xs_step(st_q);
  assign gen_inc = (gen_q == GEN_LIMIT) ? gen_q : gen_q + CNT_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    fsm_d        = fsm_q;
    st_d         = st_q;
    rnd_d        = rnd_q;
    gen_d        = gen_q;
    mask_d       = mask;
    ready_d      = ready;
    mask_valid_d = mask_valid;
    reseed_req_d = reseed_req;
    case (fsm_q)
      IDLE: begin
        if (seed_we) begin
          // An all-zero state would lock the generator at zero forever.
          st_d         = (seed == '0) ? DEFAULT_SEED : seed;
          gen_d        = '0;
          reseed_req_d = 1'b0;
          mask_valid_d = 1'b0;
        end else if (next && !reseed_req) begin
          rnd_d   = '0;
          ready_d = 1'b0;
          fsm_d   = GEN;
        end
      end
      GEN: begin
        st_d  = st_step;
        rnd_d = rnd_q + RND_W'(1);
        if (rnd_q == LAST_RND) begin
          mask_d       = st_step;
          mask_valid_d = 1'b1;
          gen_d        = gen_inc;
          reseed_req_d = (gen_inc == GEN_LIMIT);
          ready_d      = 1'b1;
          fsm_d        = IDLE;
        end
      end
      default: begin
        fsm_d   = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q      <= IDLE;
      st_q       <= DEFAULT_SEED;
      rnd_q      <= '0;
      gen_q      <= '0;
      mask       <= '0;
      ready      <= 1'b1;
      mask_valid <= 1'b0;
      reseed_req <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      st_q       <= st_d;
      rnd_q      <= rnd_d;
      gen_q      <= gen_d;
      mask       <= mask_d;
      ready      <= ready_d;
      mask_valid <= mask_valid_d;
      reseed_req <= reseed_req_d;
    end
  end

endmodule

// File: tb/tb_aes_mask_keygen.sv
// Scoreboard bench for aes_mask_keygen: instance A (ROUNDS=4) and
// instance B (ROUNDS=1, RESEED_LIMIT=2) run side by side.
module tb_aes_mask_keygen;

  localparam logic [127:0] DEF_SEED = 128'h6a09e667_bb67ae85_3c6ef372_a54ff53a;
  localparam logic [127:0] HAND_SEED = 128'h00000001_00000000_00000000_00000000;
  localparam logic [127:0] HAND_MASK = 128'h00000000_00000000_00000000_00000809;
  localparam logic [127:0] SEED_S    = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] SEED_IGN  = 128'hdeadbeef_cafebabe_00c0ffee_12345678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic         a_rst_n, a_seed_we, a_next, a_ready, a_mask_valid, a_reseed_req;
  logic [127:0] a_seed, a_mask;
  logic         b_rst_n, b_seed_we, b_next, b_ready, b_mask_valid, b_reseed_req;
  logic [127:0] b_seed, b_mask;

  logic [127:0] a_q[$];
  logic [127:0] b_q[$];
  logic [127:0] a_state, b_state;
  logic         a_done = 1'b0;
  logic         b_done = 1'b0;

  aes_mask_keygen #(.ROUNDS(4), .RESEED_LIMIT(1024)) dut_a (
    .clk(clk), .reset_n(a_rst_n), .seed_we(a_seed_we), .seed(a_seed),
    .next(a_next), .ready(a_ready), .mask(a_mask),
    .mask_valid(a_mask_valid), .reseed_req(a_reseed_req)
  );

  aes_mask_keygen #(.ROUNDS(1), .RESEED_LIMIT(2)) dut_b (
    .clk(clk), .reset_n(b_rst_n), .seed_we(b_seed_we), .seed(b_seed),
    .next(b_next), .ready(b_ready), .mask(b_mask),
    .mask_valid(b_mask_valid), .reseed_req(b_reseed_req)
  );

  // Reference xorshift128 step.
  function automatic logic [127:0] ref_step(input logic [127:0] s);
    logic [31:0] x, y, z, w, t;
    x = s[127:96]; y = s[95:64]; z = s[63:32]; w = s[31:0];
    t = x ^ (x << 11);
    return {y, z, w, w ^ (w >> 19) ^ t ^ (t >> 8)};
  endfunction

  function automatic logic [127:0] ref_steps(input logic [127:0] s, input int n);
    logic [127:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = ref_step(r);
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: a 0->1 transition of ready outside reset marks a completed mask.
  logic a_prev_rdy = 1'b1;
  always @(negedge clk) begin
    if (a_rst_n === 1'b1 && a_ready === 1'b1 && a_prev_rdy === 1'b0) begin
      if (a_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_mask: got %h expected none", a_mask);
      end else begin
        check("a_mask", a_mask, a_q.pop_front());
        check("a_mask_valid", 128'(a_mask_valid), 128'(1));
      end
    end
    a_prev_rdy = a_ready;
  end

  logic b_prev_rdy = 1'b1;
  always @(negedge clk) begin
    if (b_rst_n === 1'b1 && b_ready === 1'b1 && b_prev_rdy === 1'b0) begin
      if (b_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_mask: got %h expected none", b_mask);
      end else begin
        check("b_mask", b_mask, b_q.pop_front());
        check("b_mask_valid", 128'(b_mask_valid), 128'(1));
      end
    end
    b_prev_rdy = b_ready;
  end

  // Pulse next, then count cycles with ready low (bounded).
  task automatic a_gen(output int cnt);
    @(negedge clk); a_next = 1'b1;
    @(negedge clk); a_next = 1'b0;
    cnt = 0;
    while (!a_ready && cnt < 50) begin cnt++; @(negedge clk); end
  endtask

  task automatic b_gen(output int cnt);
    @(negedge clk); b_next = 1'b1;
    @(negedge clk); b_next = 1'b0;
    cnt = 0;
    while (!b_ready && cnt < 50) begin cnt++; @(negedge clk); end
  endtask

  // Instance A: reset, latency, ignored inputs, seed/next collision, mid-gen reset.
  initial begin
    int cnt;
    a_rst_n = 1'b1; a_seed_we = 1'b0; a_next = 1'b0; a_seed = '0;
    a_state = DEF_SEED;
    #1 a_rst_n = 1'b0;
    #1;
    check("a_rst_ready", 128'(a_ready), 128'(1));
    check("a_rst_mask", a_mask, '0);
    check("a_rst_valid", 128'(a_mask_valid), 128'(0));
    check("a_rst_reseed", 128'(a_reseed_req), 128'(0));
    repeat (2) @(negedge clk);
    #2 a_rst_n = 1'b1;

    a_state = ref_steps(a_state, 4);
    a_q.push_back(a_state);
    a_gen(cnt);
    check("a_low_cycles", 128'(cnt), 128'(4));
    check("a_mask_nonzero", 128'(a_mask != '0), 128'(1));

    // next and seed_we pulsed mid-generation must be dropped.
    @(negedge clk); a_next = 1'b1;
    a_state = ref_steps(a_state, 4);
    a_q.push_back(a_state);
    @(negedge clk); a_next = 1'b1; a_seed_we = 1'b1; a_seed = SEED_IGN;
    @(negedge clk); a_next = 1'b0; a_seed_we = 1'b0;
    cnt = 0;
    while (!a_ready && cnt < 50) begin cnt++; @(negedge clk); end
    check("a_ign_low_cycles", 128'(cnt), 128'(3));
    repeat (3) begin
      @(negedge clk);
      check("a_ign_ready", 128'(a_ready), 128'(1));
    end

    // Seed load wins over a simultaneous next.
    @(negedge clk); a_seed_we = 1'b1; a_next = 1'b1; a_seed = SEED_S;
    @(negedge clk); a_seed_we = 1'b0; a_next = 1'b0;
    check("a_coll_ready0", 128'(a_ready), 128'(1));
    check("a_coll_valid", 128'(a_mask_valid), 128'(0));
    @(negedge clk);
    check("a_coll_ready1", 128'(a_ready), 128'(1));
    a_state = ref_steps(SEED_S, 4);
    a_q.push_back(a_state);
    a_gen(cnt);
    check("a_coll_low_cycles", 128'(cnt), 128'(4));

    // Reset on the second generation cycle aborts without publishing.
    @(negedge clk); a_next = 1'b1;
    @(negedge clk); a_next = 1'b0;
    @(negedge clk);
    check("a_mid_busy", 128'(a_ready), 128'(0));
    #2 a_rst_n = 1'b0;
    #1;
    check("a_mid_ready", 128'(a_ready), 128'(1));
    check("a_mid_mask", a_mask, '0);
    check("a_mid_valid", 128'(a_mask_valid), 128'(0));
    check("a_mid_reseed", 128'(a_reseed_req), 128'(0));
    @(negedge clk);
    #2 a_rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("a_post_rst_ready", 128'(a_ready), 128'(1));
    check("a_post_rst_mask", a_mask, '0);
    a_state = ref_steps(DEF_SEED, 4);
    a_q.push_back(a_state);
    a_gen(cnt);
    check("a_post_rst_cycles", 128'(cnt), 128'(4));
    repeat (2) @(negedge clk);
    a_done = 1'b1;
  end

  // Instance B: hand vector, reseed budget, zero seed.
  initial begin
    int cnt;
    b_rst_n = 1'b1; b_seed_we = 1'b0; b_next = 1'b0; b_seed = '0;
    #1 b_rst_n = 1'b0;
    #1;
    check("b_rst_ready", 128'(b_ready), 128'(1));
    repeat (2) @(negedge clk);
    #2 b_rst_n = 1'b1;

    @(negedge clk); b_seed_we = 1'b1; b_seed = HAND_SEED;
    @(negedge clk); b_seed_we = 1'b0;
    b_q.push_back(HAND_MASK);
    b_state = HAND_MASK;
    b_gen(cnt);
    check("b_low_cycles", 128'(cnt), 128'(1));
    check("b_reseed_after1", 128'(b_reseed_req), 128'(0));

    b_state = ref_step(b_state);
    b_q.push_back(b_state);
    b_gen(cnt);
    check("b_reseed_after2", 128'(b_reseed_req), 128'(1));

    // Budget exhausted: next is ignored.
    @(negedge clk); b_next = 1'b1;
    @(negedge clk); b_next = 1'b0;
    repeat (3) begin
      check("b_blocked_ready", 128'(b_ready), 128'(1));
      @(negedge clk);
    end
    check("b_blocked_mask", b_mask, b_state);
    check("b_blocked_reseed", 128'(b_reseed_req), 128'(1));

    // Zero seed reloads the default seed and clears status but not mask.
    @(negedge clk); b_seed_we = 1'b1; b_seed = '0;
    @(negedge clk); b_seed_we = 1'b0;
    check("b_seed_reseed", 128'(b_reseed_req), 128'(0));
    check("b_seed_valid", 128'(b_mask_valid), 128'(0));
    check("b_seed_mask_kept", b_mask, b_state);
    b_state = ref_step(DEF_SEED);
    b_q.push_back(b_state);
    b_gen(cnt);
    check("b_zero_seed_cycles", 128'(cnt), 128'(1));
    check("b_zero_seed_nonzero", 128'(b_mask != '0), 128'(1));
    repeat (2) @(negedge clk);
    b_done = 1'b1;
  end

  // Completion, drain check and summary.
  initial begin
    int i;
    i = 0;
    while (!(a_done && b_done) && i < 5000) begin i++; @(negedge clk); end
    if (!(a_done && b_done)) begin
      checks++;
      failures++;
      $display("FAIL timeout: got a_done=%0b b_done=%0b expected both 1", a_done, b_done);
    end
    check("a_queue_drained", 128'(a_q.size()), 128'(0));
    check("b_queue_drained", 128'(b_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
